// File: rtl/cc_level_sequencer_pkg.sv
// Shared types and default sizing for the level sequencer and its progress counter.
package cc_level_sequencer_pkg;

  localparam int unsigned MAX_LEVEL               = 3;
  localparam int unsigned ROWS_PER_LEVEL          = 12;
  localparam int unsigned LEVELPROGRESS_DATAWIDTH = 5;
  localparam int unsigned CURRENTLEVEL_DATAWIDTH  = 3;
  localparam int unsigned ROWDATA_DATAWIDTH       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    WIN  = 2'd3
  } seqState_t;

  // Commands the sequencer FSM issues to the progress/level counter each cycle.
  typedef enum logic [2:0] {
    CMD_HOLD     = 3'd0,
    CMD_CLEAR    = 3'd1,
    CMD_START    = 3'd2,
    CMD_TICK     = 3'd3,
    CMD_LEVEL_UP = 3'd4
  } counterCmd_t;

endpackage

// File: rtl/cc_level_progress_counter.sv
// Progress index with 1..ROW_COUNT wrap and level index saturating at LEVEL_MAX.
module cc_level_progress_counter
  import cc_level_sequencer_pkg::*;
#(
  parameter int unsigned LEVEL_MAX  = MAX_LEVEL,
  parameter int unsigned ROW_COUNT  = ROWS_PER_LEVEL,
  parameter int unsigned PROGRESS_W = LEVELPROGRESS_DATAWIDTH,
  parameter int unsigned LEVEL_W    = CURRENTLEVEL_DATAWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  counterCmd_t           cmd,
  output logic [PROGRESS_W-1:0] progress,
  output logic [LEVEL_W-1:0]    level,
  output logic                  atMaxLevel_c
);

  logic [PROGRESS_W-1:0] progressNext;
  logic [LEVEL_W-1:0]    levelNext;

  assign atMaxLevel_c = (level >= LEVEL_W'(LEVEL_MAX));

  // Next index values; progress wraps back to 1, never to 0 or past ROW_COUNT.
  always_comb begin
    progressNext = progress;
    levelNext    = level;
    unique case (cmd)
      CMD_CLEAR: begin
        progressNext = '0;
        levelNext    = LEVEL_W'(1);
      end
      CMD_START: begin
        progressNext = PROGRESS_W'(1);
        levelNext    = LEVEL_W'(1);
      end
      CMD_TICK: begin
        if (progress >= PROGRESS_W'(ROW_COUNT)) progressNext = PROGRESS_W'(1);
        else                                    progressNext = progress + PROGRESS_W'(1);
      end
      CMD_LEVEL_UP: begin
        if (atMaxLevel_c) begin
          progressNext = '0;
        end else begin
          levelNext    = level + LEVEL_W'(1);
          progressNext = PROGRESS_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Index registers; reset parks at progress 0, level 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      progress <= '0;
      level    <= LEVEL_W'(1);
    end else begin
      progress <= progressNext;
      level    <= levelNext;
    end
  end

endmodule

// File: rtl/cc_level_sequencer.sv
// Level sequencer: steps the handler indices on ticks/level-ups and registers the returned row.
module cc_level_sequencer #(
  parameter int unsigned MAX_LEVEL               = cc_level_sequencer_pkg::MAX_LEVEL,
  parameter int unsigned ROWS_PER_LEVEL          = cc_level_sequencer_pkg::ROWS_PER_LEVEL,
  parameter int unsigned LEVELPROGRESS_DATAWIDTH = cc_level_sequencer_pkg::LEVELPROGRESS_DATAWIDTH,
  parameter int unsigned CURRENTLEVEL_DATAWIDTH  = cc_level_sequencer_pkg::CURRENTLEVEL_DATAWIDTH,
  parameter int unsigned ROWDATA_DATAWIDTH       = cc_level_sequencer_pkg::ROWDATA_DATAWIDTH
) (
  input  logic                               CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                               CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                               CC_LEVEL_SEQUENCER_Start_In,
  input  logic                               CC_LEVEL_SEQUENCER_Tick_In,
  input  logic                               CC_LEVEL_SEQUENCER_LevelUp_In,
  input  logic                               CC_LEVEL_SEQUENCER_GameOver_In,
  input  logic [ROWDATA_DATAWIDTH-1:0]       CC_LEVEL_SEQUENCER_LevelData_InBus,
  output logic [LEVELPROGRESS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_LvlProgress_OutBus,
  output logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_CurrentLvl_OutBus,
  output logic [ROWDATA_DATAWIDTH-1:0]       CC_LEVEL_SEQUENCER_RowData_OutBus,
  output logic                               CC_LEVEL_SEQUENCER_RowLoad_Out,
  output logic                               CC_LEVEL_SEQUENCER_LevelDone_Out,
  output logic                               CC_LEVEL_SEQUENCER_Win_Out
);

  import cc_level_sequencer_pkg::*;

  seqState_t                    state;
  seqState_t                    nextState;
  counterCmd_t                  counterCmd;
  logic                         atMaxLevel;
  logic [ROWDATA_DATAWIDTH-1:0] rowDataNext;
  logic                         rowLoadNext;
  logic                         levelDoneNext;
  logic                         winNext;

  cc_level_progress_counter #(
    .LEVEL_MAX  (MAX_LEVEL),
    .ROW_COUNT  (ROWS_PER_LEVEL),
    .PROGRESS_W (LEVELPROGRESS_DATAWIDTH),
    .LEVEL_W    (CURRENTLEVEL_DATAWIDTH)
  ) progressCounter (
    .clk          (CC_LEVEL_SEQUENCER_CLOCK_50),
    .rst_n        (CC_LEVEL_SEQUENCER_RESET_InLow),
    .cmd          (counterCmd),
    .progress     (CC_LEVEL_SEQUENCER_LvlProgress_OutBus),
    .level        (CC_LEVEL_SEQUENCER_CurrentLvl_OutBus),
    .atMaxLevel_c (atMaxLevel)
  );

  // State register.
  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or negedge CC_LEVEL_SEQUENCER_RESET_InLow) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) state <= IDLE;
    else                                 state <= nextState;
  end

  // Next state: GameOver beats LevelUp beats Tick; losers are simply dropped.
  always_comb begin
    nextState = state;
    if (CC_LEVEL_SEQUENCER_GameOver_In) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE, WIN: if (CC_LEVEL_SEQUENCER_Start_In) nextState = LOAD;
        LOAD:      nextState = WAIT;
        WAIT: begin
          if (CC_LEVEL_SEQUENCER_LevelUp_In) nextState = atMaxLevel ? WIN : LOAD;
          else if (CC_LEVEL_SEQUENCER_Tick_In) nextState = LOAD;
        end
        default:   nextState = IDLE;
      endcase
    end
  end

  // Output decode: counter command plus next values of the registered outputs.
  always_comb begin
    counterCmd    = CMD_HOLD;
    rowDataNext   = CC_LEVEL_SEQUENCER_RowData_OutBus;
    rowLoadNext   = 1'b0;
    levelDoneNext = 1'b0;
    winNext       = (nextState == WIN);
    if (CC_LEVEL_SEQUENCER_GameOver_In) begin
      counterCmd  = CMD_CLEAR;
      rowDataNext = '0;
    end else begin
      unique case (state)
        IDLE, WIN: if (CC_LEVEL_SEQUENCER_Start_In) counterCmd = CMD_START;
        LOAD: begin
          rowDataNext = CC_LEVEL_SEQUENCER_LevelData_InBus;
          rowLoadNext = 1'b1;
        end
        WAIT: begin
          if (CC_LEVEL_SEQUENCER_LevelUp_In) begin
            counterCmd    = CMD_LEVEL_UP;
            levelDoneNext = 1'b1;
          end else if (CC_LEVEL_SEQUENCER_Tick_In) begin
            counterCmd = CMD_TICK;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered row data and status pulses.
  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or negedge CC_LEVEL_SEQUENCER_RESET_InLow) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
      CC_LEVEL_SEQUENCER_RowData_OutBus <= '0;
      CC_LEVEL_SEQUENCER_RowLoad_Out    <= 1'b0;
      CC_LEVEL_SEQUENCER_LevelDone_Out  <= 1'b0;
      CC_LEVEL_SEQUENCER_Win_Out        <= 1'b0;
    end else begin
      CC_LEVEL_SEQUENCER_RowData_OutBus <= rowDataNext;
      CC_LEVEL_SEQUENCER_RowLoad_Out    <= rowLoadNext;
      CC_LEVEL_SEQUENCER_LevelDone_Out  <= levelDoneNext;
      CC_LEVEL_SEQUENCER_Win_Out        <= winNext;
    end
  end

endmodule

// File: doc/cc_level_sequencer.md
CC_LEVEL_SEQUENCER -- requirements
Module: cc_level_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 3: highest playable level.
REQ-002 SHALL have parameter ROWS_PER_LEVEL, default 12: progress steps per level.
REQ-003 SHALL have parameter LEVELPROGRESS_DATAWIDTH, default 5: progress bus width.
REQ-004 SHALL have parameter CURRENTLEVEL_DATAWIDTH, default 3: level bus width.
REQ-005 SHALL have parameter ROWDATA_DATAWIDTH, default 8: row data width.
REQ-006 SHALL have CC_LEVEL_SEQUENCER_CLOCK_50  in  1  system clock; the block uses one clock.
REQ-007 SHALL have CC_LEVEL_SEQUENCER_RESET_InLow  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have CC_LEVEL_SEQUENCER_Start_In  in  1  start pulse, used in IDLE or WIN.
REQ-009 SHALL have CC_LEVEL_SEQUENCER_Tick_In  in  1  one-cycle scroll tick.
REQ-010 SHALL have CC_LEVEL_SEQUENCER_LevelUp_In  in  1  frog reached goal pulse.
REQ-011 SHALL have CC_LEVEL_SEQUENCER_GameOver_In  in  1  abort pulse.
REQ-012 SHALL have CC_LEVEL_SEQUENCER_LevelData_InBus  in  ROWDATA_DATAWIDTH  row data from the level data handler.
REQ-013 SHALL have CC_LEVEL_SEQUENCER_LvlProgress_OutBus  out  LEVELPROGRESS_DATAWIDTH  progress index to the handler.
REQ-014 SHALL have CC_LEVEL_SEQUENCER_CurrentLvl_OutBus  out  CURRENTLEVEL_DATAWIDTH  level index to the handler.
REQ-015 SHALL have CC_LEVEL_SEQUENCER_RowData_OutBus  out  ROWDATA_DATAWIDTH  registered row data.
REQ-016 SHALL have CC_LEVEL_SEQUENCER_RowLoad_Out  out  1  one-cycle pulse when RowData updates.
REQ-017 SHALL have CC_LEVEL_SEQUENCER_LevelDone_Out  out  1  one-cycle pulse on level advance.
REQ-018 SHALL have CC_LEVEL_SEQUENCER_Win_Out  out  1  high while in WIN.

Function
REQ-019 SHALL implement the states IDLE, LOAD, WAIT, WIN, all registered.
REQ-020 In IDLE, Start SHALL set progress to 1 and level to 1, then go to LOAD.
REQ-021 In LOAD, the block SHALL capture LevelData_InBus into RowData and pulse RowLoad for exactly one cycle, then go to WAIT.
REQ-022 Because the handler is combinational on the registered indices, the row data SHALL be valid in the same LOAD cycle; latency from Tick to RowLoad SHALL be 2 cycles.
REQ-023 In WAIT, Tick SHALL increment progress; at progress ROWS_PER_LEVEL it SHALL wrap to 1 (never 0 or 13); the next state SHALL be LOAD.
REQ-024 In WAIT, LevelUp SHALL pulse LevelDone.
REQ-025 On LevelUp with level < MAX_LEVEL, the block SHALL increment the level, set progress to 1, and go to LOAD.
REQ-026 On LevelUp with level == MAX_LEVEL, the block SHALL go to WIN with progress 0.
REQ-027 Event priority SHALL be GameOver > LevelUp > Tick; a lower event in the same cycle SHALL be dropped, not queued.
REQ-028 GameOver in any state SHALL go to IDLE with progress 0, level 1, RowData 0, and no RowLoad pulse.
REQ-029 Tick and LevelUp SHALL be ignored in IDLE, LOAD and WIN.
REQ-030 In WIN, Win_Out SHALL be 1 and indices SHALL hold; Start SHALL behave as in REQ-020.
REQ-031 The level SHALL never exceed MAX_LEVEL and progress SHALL never exceed ROWS_PER_LEVEL.

Reset
REQ-032 Reset asserted SHALL immediately force IDLE, progress 0, level 1, RowData 0, and RowLoad/LevelDone/Win 0, including when asserted mid-LOAD.
REQ-033 After reset releases, the block SHALL require Start before any RowLoad.

Structure
REQ-034 A shared package SHALL hold the state encoding, MAX_LEVEL, ROWS_PER_LEVEL and the bus widths.
REQ-035 Progress wrap and level saturation SHALL live in one sub-module, cc_level_progress_counter; the FSM and row register stay in the top.

Verification
REQ-036 Bench SHALL cover: reset, Start, then one cycle with the handler connected -> progress 1, level 1, RowData 0x10, one RowLoad pulse.
REQ-037 Bench SHALL cover: 12 Ticks from progress 1 -> progress sequence 2..12, then 1; exactly 12 RowLoad pulses.
REQ-038 Bench SHALL cover: LevelUp at level 1, progress 7 -> level 2, progress 1, one LevelDone pulse, RowLoad 1 cycle later.
REQ-039 Bench SHALL cover: LevelUp at level 3 -> WIN, Win 1, progress 0; later Tick causes no change; Start -> level 1, progress 1.
REQ-040 Bench SHALL cover: GameOver, LevelUp and Tick in the same cycle while in WAIT -> IDLE, level 1, progress 0, no LevelDone.
REQ-041 Bench SHALL cover: reset asserted during LOAD -> outputs 0 and level 1 with no clock edge; no RowLoad pulse.
